// File: rtl/test_mode_pkg.sv
// Shared types, register addresses and mode encodings for the ADC test-mode
// configuration controller.
package test_mode_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LATCH,
        SETTLE,
        APPLY
    } tm_state_t;

    localparam logic [7:0] ADDR_TEST_MODE = 8'h0D;
    localparam logic [7:0] ADDR_UP1_L     = 8'h19;
    localparam logic [7:0] ADDR_UP1_H     = 8'h1A;
    localparam logic [7:0] ADDR_UP2_L     = 8'h1B;
    localparam logic [7:0] ADDR_UP2_H     = 8'h1C;
    localparam logic [7:0] ADDR_UP3_L     = 8'h1D;
    localparam logic [7:0] ADDR_UP3_H     = 8'h1E;
    localparam logic [7:0] ADDR_UP4_L     = 8'h1F;
    localparam logic [7:0] ADDR_UP4_H     = 8'h20;
    localparam logic [7:0] ADDR_XFER      = 8'hFF;

    localparam logic [3:0] MODE_NORMAL = 4'b0000;
    localparam logic [3:0] MODE_USER   = 4'b1000;

    // pattern[0] is user pattern 1
    typedef struct packed {
        logic [3:0]       mode;
        logic             user_ctrl;
        logic             rst_pn_long;
        logic             rst_pn_short;
        logic [3:0][15:0] pattern;
    } tm_cfg_t;

endpackage

// File: rtl/tm_cfg_regfile.sv
// Host-visible shadow registers: write decode, transfer strobe detection and a
// registered read mux that returns the pre-write value on a same-cycle access.
module tm_cfg_regfile
    import test_mode_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [7:0]        wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic              xfer_status_i,
    output logic [7:0]        rd_data_o,
    output tm_cfg_t           shadow_o,
    output logic              xfer_req_o
);

    localparam logic [ADDR_W-1:0] ATm   = ADDR_W'(ADDR_TEST_MODE);
    localparam logic [ADDR_W-1:0] AUp1L = ADDR_W'(ADDR_UP1_L);
    localparam logic [ADDR_W-1:0] AUp1H = ADDR_W'(ADDR_UP1_H);
    localparam logic [ADDR_W-1:0] AUp2L = ADDR_W'(ADDR_UP2_L);
    localparam logic [ADDR_W-1:0] AUp2H = ADDR_W'(ADDR_UP2_H);
    localparam logic [ADDR_W-1:0] AUp3L = ADDR_W'(ADDR_UP3_L);
    localparam logic [ADDR_W-1:0] AUp3H = ADDR_W'(ADDR_UP3_H);
    localparam logic [ADDR_W-1:0] AUp4L = ADDR_W'(ADDR_UP4_L);
    localparam logic [ADDR_W-1:0] AUp4H = ADDR_W'(ADDR_UP4_H);
    localparam logic [ADDR_W-1:0] AXfer = ADDR_W'(ADDR_XFER);

    tm_cfg_t    cfg_d, cfg_q;
    logic [7:0] rd_mux;
    logic [7:0] rd_data_d, rd_data_q;

    always_comb begin
        cfg_d = cfg_q;
        if (wr_en_i) begin
            case (wr_addr_i)
                ATm: begin
                    cfg_d.mode         = wr_data_i[3:0];
                    cfg_d.rst_pn_long  = wr_data_i[4];
                    cfg_d.rst_pn_short = wr_data_i[5];
                    cfg_d.user_ctrl    = wr_data_i[7];
                end
                AUp1L:   cfg_d.pattern[0][7:0]  = wr_data_i;
                AUp1H:   cfg_d.pattern[0][15:8] = wr_data_i;
                AUp2L:   cfg_d.pattern[1][7:0]  = wr_data_i;
                AUp2H:   cfg_d.pattern[1][15:8] = wr_data_i;
                AUp3L:   cfg_d.pattern[2][7:0]  = wr_data_i;
                AUp3H:   cfg_d.pattern[2][15:8] = wr_data_i;
                AUp4L:   cfg_d.pattern[3][7:0]  = wr_data_i;
                AUp4H:   cfg_d.pattern[3][15:8] = wr_data_i;
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_mux = 8'h00;
        case (rd_addr_i)
            ATm:     rd_mux = {cfg_q.user_ctrl, 1'b0, cfg_q.rst_pn_short,
                               cfg_q.rst_pn_long, cfg_q.mode};
            AUp1L:   rd_mux = cfg_q.pattern[0][7:0];
            AUp1H:   rd_mux = cfg_q.pattern[0][15:8];
            AUp2L:   rd_mux = cfg_q.pattern[1][7:0];
            AUp2H:   rd_mux = cfg_q.pattern[1][15:8];
            AUp3L:   rd_mux = cfg_q.pattern[2][7:0];
            AUp3H:   rd_mux = cfg_q.pattern[2][15:8];
            AUp4L:   rd_mux = cfg_q.pattern[3][7:0];
            AUp4H:   rd_mux = cfg_q.pattern[3][15:8];
            AXfer:   rd_mux = {7'b0, xfer_status_i};
            default: ;
        endcase
        rd_data_d = rd_en_i ? rd_mux : rd_data_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cfg_q     <= '0;
            rd_data_q <= 8'h00;
        end else begin
            cfg_q     <= cfg_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data_o  = rd_data_q;
    assign shadow_o   = cfg_q;
    assign xfer_req_o = wr_en_i && (wr_addr_i == AXfer) && wr_data_i[0];

endmodule

// File: rtl/test_mode_cfg_ctrl.sv
// Test-mode configuration controller: stages shadow config on a transfer command
// and applies it to the datapath, parking in normal mode while a mode change settles.
module test_mode_cfg_ctrl
    import test_mode_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned ADDR_W        = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic [3:0]        select_mode,
    output logic              user_test_mode_control,
    output logic              reset_PN_long_gen,
    output logic              reset_PN_short_gen,
    output logic [15:0]       user_pattern_1,
    output logic [15:0]       user_pattern_2,
    output logic [15:0]       user_pattern_3,
    output logic [15:0]       user_pattern_4,
    output logic              busy,
    output logic              xfer_done
);

    localparam int unsigned   CntW    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLoad = CntW'(SETTLE_CYCLES - 1);

    tm_state_t       state_d, state_q;
    logic [CntW-1:0] cnt_d, cnt_q;
    logic            pend_d, pend_q;
    tm_cfg_t         snap_d, snap_q;
    tm_cfg_t         act_d, act_q;
    logic [3:0]      sel_d, sel_q;
    logic            done_d, done_q;
    tm_cfg_t         shadow;
    logic            xfer_req;
    logic            xfer_status;

    tm_cfg_regfile #(
        .ADDR_W (ADDR_W)
    ) u_regfile (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .wr_en_i       (wr_en),
        .wr_addr_i     (wr_addr),
        .wr_data_i     (wr_data),
        .rd_en_i       (rd_en),
        .rd_addr_i     (rd_addr),
        .xfer_status_i (xfer_status),
        .rd_data_o     (rd_data),
        .shadow_o      (shadow),
        .xfer_req_o    (xfer_req)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        snap_d  = snap_q;
        act_d   = act_q;
        sel_d   = sel_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (xfer_req || pend_q) begin
                    state_d = LATCH;
                end
            end
            LATCH: begin
                snap_d = shadow;
                pend_d = 1'b0;
                if (shadow.mode == act_q.mode) begin
                    state_d = APPLY;
                end else begin
                    sel_d   = MODE_NORMAL;
                    cnt_d   = CntLoad;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = APPLY;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            APPLY: begin
                act_d   = snap_q;
                sel_d   = snap_q.mode;
                done_d  = 1'b1;
                state_d = IDLE;
            end
        endcase

        // A request arriving once a transfer is underway (even in LATCH) is queued
        if (xfer_req && (state_q != IDLE)) begin
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            snap_q  <= '0;
            act_q   <= '0;
            sel_q   <= MODE_NORMAL;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            snap_q  <= snap_d;
            act_q   <= act_d;
            sel_q   <= sel_d;
            done_q  <= done_d;
        end
    end

    assign xfer_status            = pend_q || (state_q != IDLE);
    assign busy                   = (state_q == LATCH) || (state_q == SETTLE);
    // Pulse is registered so it lines up with the first cycle the new config is live
    assign xfer_done              = done_q;
    assign select_mode            = sel_q;
    assign user_test_mode_control = act_q.user_ctrl;
    assign reset_PN_long_gen      = act_q.rst_pn_long;
    assign reset_PN_short_gen     = act_q.rst_pn_short;
    assign user_pattern_1         = act_q.pattern[0];
    assign user_pattern_2         = act_q.pattern[1];
    assign user_pattern_3         = act_q.pattern[2];
    assign user_pattern_4         = act_q.pattern[3];

endmodule
